// File: rtl/reg_bank_ctrl_pkg.sv
// reg_bank_pkg: shared constants, the address-region type and the region
// decoder used by the register bank controller.
//   DATA_W        register/bus data width
//   OOR_RDATA     read data returned for an out-of-range word index
//   region_t      control / status / out-of-range classification
//   decode_region word index -> region, given the two region sizes
package reg_bank_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] OOR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    REGION_CTRL = 2'd0,
    REGION_STAT = 2'd1,
    REGION_OOR  = 2'd2
  } region_t;

  // Control words sit at 0..n_ctrl-1, status words directly above them.
  function automatic region_t decode_region(input logic [31:0] idx,
                                            input int n_ctrl,
                                            input int n_stat);
    region_t r;
    if (idx < 32'(n_ctrl))               r = REGION_CTRL;
    else if (idx < 32'(n_ctrl + n_stat)) r = REGION_STAT;
    else                                 r = REGION_OOR;
    return r;
  endfunction

endpackage

// File: rtl/reg_bank_ctrl_if.sv
// reg_bank_ctrl_if: BRAM-controller style access port.
//   bram_en      access enable
//   bram_we      byte write enables (nonzero = write, zero = read)
//   bram_addr    byte address; word index is bram_addr[ADDR_W-1:2]
//   bram_wrdata  write data
//   bram_rddata  registered read data
// master = host side (bridge), slave = register bank.
interface reg_bank_ctrl_if #(parameter int ADDR_W = 12);
  import reg_bank_pkg::*;

  logic              bram_en;
  logic [3:0]        bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wrdata;
  logic [DATA_W-1:0] bram_rddata;

  modport master (output bram_en, bram_we, bram_addr, bram_wrdata,
                  input  bram_rddata);
  modport slave  (input  bram_en, bram_we, bram_addr, bram_wrdata,
                  output bram_rddata);
endinterface

// File: rtl/reg_bank_ctrl_addr_dec.sv
// reg_bank_addr_dec: combinational access decode for the register bank.
// Inputs : en, we, addr (raw BRAM port fields)
// Outputs: region    - control / status / out-of-range
//          ctrl_idx  - word index into the control array
//          stat_idx  - word index into the status shadow
//          wr_ctrl   - accepted write to a control register
//          rd        - read access (any region)
//          oor       - any access to an out-of-range index
//          pulse     - index falls in the self-clearing pulse range
//          snap_wr   - accepted write to the snapshot pulse register
module reg_bank_addr_dec
  import reg_bank_pkg::*;
#(
  parameter int N_CTRL   = 512,
  parameter int N_STAT   = 512,
  parameter int ADDR_W   = 12,
  parameter int N_PULSE  = 8,
  parameter int SNAP_IDX = 0,
  localparam int CIDX_W  = $clog2(N_CTRL),
  localparam int SIDX_W  = $clog2(N_STAT),
  localparam int IDX_W   = ADDR_W - 2
)(
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  output region_t           region,
  output logic [CIDX_W-1:0] ctrl_idx,
  output logic [SIDX_W-1:0] stat_idx,
  output logic              wr_ctrl,
  output logic              rd,
  output logic              oor,
  output logic              pulse,
  output logic              snap_wr
);

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] stat_off;
  logic [31:0]      idx32;
  logic             unused_bits;

  always_comb begin
    idx      = addr[ADDR_W-1:2];
    idx32    = 32'(idx);
    stat_off = idx - IDX_W'(N_CTRL);
    region   = decode_region(idx32, N_CTRL, N_STAT);
    ctrl_idx = idx[CIDX_W-1:0];
    stat_idx = stat_off[SIDX_W-1:0];
    pulse    = idx32 < 32'(N_PULSE);
    // Writes outside the control region are dropped, so only these count.
    wr_ctrl  = en && (we != 4'b0) && (region == REGION_CTRL);
    rd       = en && (we == 4'b0);
    oor      = en && (region == REGION_OOR);
    snap_wr  = wr_ctrl && (idx32 == 32'(SNAP_IDX));
  end

  // Byte-lane bits and the upper offset bits carry no information here.
  assign unused_bits = ^{addr[1:0], stat_off};

endmodule

// File: rtl/reg_bank_ctrl.sv
// reg_bank_ctrl: parametrised control/status register bank on a BRAM port.
// Ports:
//   user_clk, user_areset  clock and asynchronous active-high reset
//   bram                   BRAM access port (slave side)
//   ctrl_reg               control register outputs, word i at [32i+31:32i]
//   stat_reg               status inputs from user logic
//   ctrl_wr_valid/_idx     one-cycle strobe + index after each control write
//   oor_count              saturating count of out-of-range accesses
// Pulse registers (indices < N_PULSE) hold a written value for one cycle and
// read back as zero. The status shadow either follows stat_reg every cycle
// (SNAP_MODE=0) or is captured whole when the SNAP_IDX pulse is visible.
module reg_bank_ctrl
  import reg_bank_pkg::*;
#(
  parameter int N_CTRL    = 512,
  parameter int N_STAT    = 512,
  parameter int ADDR_W    = 12,
  parameter int N_PULSE   = 8,
  parameter int SNAP_MODE = 0,
  parameter int SNAP_IDX  = 0,
  localparam int CIDX_W   = $clog2(N_CTRL),
  localparam int SIDX_W   = $clog2(N_STAT)
)(
  input  logic                     user_clk,
  input  logic                     user_areset,
  reg_bank_ctrl_if.slave           bram,
  output logic [N_CTRL*DATA_W-1:0] ctrl_reg,
  input  logic [N_STAT*DATA_W-1:0] stat_reg,
  output logic                     ctrl_wr_valid,
  output logic [CIDX_W-1:0]        ctrl_wr_idx,
  output logic [15:0]              oor_count
);

  region_t           region;
  logic [CIDX_W-1:0] ctrl_idx;
  logic [SIDX_W-1:0] stat_idx;
  logic              wr_ctrl, rd, oor, pulse, snap_wr;

  reg_bank_addr_dec #(
    .N_CTRL  (N_CTRL),
    .N_STAT  (N_STAT),
    .ADDR_W  (ADDR_W),
    .N_PULSE (N_PULSE),
    .SNAP_IDX(SNAP_IDX)
  ) u_dec (
    .en      (bram.bram_en),
    .we      (bram.bram_we),
    .addr    (bram.bram_addr),
    .region  (region),
    .ctrl_idx(ctrl_idx),
    .stat_idx(stat_idx),
    .wr_ctrl (wr_ctrl),
    .rd      (rd),
    .oor     (oor),
    .pulse   (pulse),
    .snap_wr (snap_wr)
  );

  logic [N_CTRL-1:0][DATA_W-1:0] ctrl_q, ctrl_d;
  logic [N_STAT-1:0][DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0]             rdata_q, rdata_d;
  logic                          snap_q, snap_d;
  logic                          wr_valid_q, wr_valid_d;
  logic [CIDX_W-1:0]             wr_idx_q, wr_idx_d;
  logic [15:0]                   oor_q, oor_d;

  always_comb begin
    // Pulse registers fall back to zero unless rewritten this cycle; a
    // rewrite merges onto zero, not onto the value currently visible.
    ctrl_d = ctrl_q;
    for (int i = 0; i < N_PULSE; i++) ctrl_d[CIDX_W'(i)] = '0;
    if (wr_ctrl) begin
      for (int b = 0; b < 4; b++)
        if (bram.bram_we[b]) ctrl_d[ctrl_idx][8*b +: 8] = bram.bram_wrdata[8*b +: 8];
    end

    // Read data holds between reads; writes never disturb it.
    rdata_d = rdata_q;
    if (rd) begin
      case (region)
        REGION_CTRL: rdata_d = pulse ? '0 : ctrl_q[ctrl_idx];
        REGION_STAT: rdata_d = shadow_q[stat_idx];
        default:     rdata_d = OOR_RDATA;
      endcase
    end

    // snap_q marks the cycle the snapshot pulse is visible on ctrl_reg.
    snap_d   = (SNAP_MODE != 0) && snap_wr;
    shadow_d = shadow_q;
    if ((SNAP_MODE == 0) || snap_q) shadow_d = stat_reg;

    wr_valid_d = wr_ctrl;
    wr_idx_d   = wr_ctrl ? ctrl_idx : wr_idx_q;
    oor_d      = (oor && (oor_q != 16'hFFFF)) ? oor_q + 16'd1 : oor_q;
  end

  always_ff @(posedge user_clk or posedge user_areset) begin
    if (user_areset) begin
      ctrl_q     <= '0;
      shadow_q   <= '0;
      rdata_q    <= '0;
      snap_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_idx_q   <= '0;
      oor_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      shadow_q   <= shadow_d;
      rdata_q    <= rdata_d;
      snap_q     <= snap_d;
      wr_valid_q <= wr_valid_d;
      wr_idx_q   <= wr_idx_d;
      oor_q      <= oor_d;
    end
  end

  assign ctrl_reg         = ctrl_q;
  assign bram.bram_rddata = rdata_q;
  assign ctrl_wr_valid    = wr_valid_q;
  assign ctrl_wr_idx      = wr_idx_q;
  assign oor_count        = oor_q;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Scoreboard bench for reg_bank_ctrl: two instances (continuous shadow and
// snapshot shadow) receive identical stimulus. The driver updates an
// array-based reference model and queues the expected post-edge state; a
// monitor pops one entry per accepted cycle and compares it.
module tb_reg_bank_ctrl;
  import reg_bank_pkg::*;

  localparam int NC   = 32;
  localparam int NS   = 16;
  localparam int AW   = 8;
  localparam int NP   = 4;
  localparam int SI   = 0;
  localparam int WW   = $clog2(NC);
  localparam int NIDX = 1 << (AW - 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_bank_ctrl_if #(.ADDR_W(AW)) bus0 ();
  reg_bank_ctrl_if #(.ADDR_W(AW)) bus1 ();

  logic [NC*32-1:0] ctrl0, ctrl1;
  logic [NS*32-1:0] stat_bus, stat_nxt;
  logic             v0, v1;
  logic [WW-1:0]    wi0, wi1;
  logic [15:0]      oc0, oc1;

  reg_bank_ctrl #(.N_CTRL(NC), .N_STAT(NS), .ADDR_W(AW), .N_PULSE(NP),
                  .SNAP_MODE(0), .SNAP_IDX(SI)) dut0 (
    .user_clk(clk), .user_areset(rst), .bram(bus0), .ctrl_reg(ctrl0),
    .stat_reg(stat_bus), .ctrl_wr_valid(v0), .ctrl_wr_idx(wi0), .oor_count(oc0));

  reg_bank_ctrl #(.N_CTRL(NC), .N_STAT(NS), .ADDR_W(AW), .N_PULSE(NP),
                  .SNAP_MODE(1), .SNAP_IDX(SI)) dut1 (
    .user_clk(clk), .user_areset(rst), .bram(bus1), .ctrl_reg(ctrl1),
    .stat_reg(stat_bus), .ctrl_wr_valid(v1), .ctrl_wr_idx(wi1), .oor_count(oc1));

  typedef struct {
    logic [NC*32-1:0] ctrl;
    logic             wv;
    logic [WW-1:0]    wi;
    logic [31:0]      rd0, rd1;
    logic [15:0]      oor;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   armed;

  // Reference model state (value after the most recently issued edge).
  logic [31:0] m_ctrl[NC];
  logic [31:0] m_sh0[NS];
  logic [31:0] m_sh1[NS];
  logic        m_snap;
  logic [31:0] m_rd0, m_rd1;
  logic [15:0] m_oor;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, want);
  endtask

  task automatic check_ctrl(input string name, input logic [NC*32-1:0] act,
                            input logic [NC*32-1:0] want);
    int bad;
    n_chk++;
    if (act === want) n_pass++;
    else begin
      bad = 0;
      for (int i = NC - 1; i >= 0; i--)
        if (act[i*32 +: 32] !== want[i*32 +: 32]) bad = i;
      $display("FAIL %s word %0d: got %h expected %h", name, bad,
               act[bad*32 +: 32], want[bad*32 +: 32]);
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] we, input logic [AW-1:0] a,
                       input logic [31:0] wd);
    bus0.bram_en = en; bus0.bram_we = we; bus0.bram_addr = a; bus0.bram_wrdata = wd;
    bus1.bram_en = en; bus1.bram_we = we; bus1.bram_addr = a; bus1.bram_wrdata = wd;
  endtask

  // A continuous shadow picks up stat_bus on the first edge after release.
  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_ctrl[i] = '0;
    for (int j = 0; j < NS; j++) begin
      m_sh0[j] = stat_bus[j*32 +: 32];
      m_sh1[j] = '0;
    end
    m_snap = 1'b0; m_rd0 = '0; m_rd1 = '0; m_oor = '0;
  endtask

  // Issue one access for the next edge and queue the state expected after it.
  task automatic do_cycle(input logic en, input logic [3:0] we, input int idx,
                          input logic [31:0] wd);
    exp_t        e;
    logic [31:0] nc[NC];
    logic [31:0] v;
    logic [AW-1:0] a;
    @(posedge clk); #1;
    a = {idx[AW-3:0], 2'($urandom_range(0, 3))};
    drive(en, we, a, wd);
    stat_bus = stat_nxt;

    if (en && we == 4'b0) begin
      if (idx < NC) begin
        m_rd0 = (idx < NP) ? 32'h0 : m_ctrl[idx];
        m_rd1 = m_rd0;
      end else if (idx < NC + NS) begin
        m_rd0 = m_sh0[idx-NC];
        m_rd1 = m_sh1[idx-NC];
      end else begin
        m_rd0 = 32'hDEAD_BEEF;
        m_rd1 = 32'hDEAD_BEEF;
      end
    end
    if (en && idx >= NC + NS && m_oor != 16'hFFFF) m_oor = m_oor + 16'd1;

    for (int i = 0; i < NC; i++) nc[i] = (i < NP) ? 32'h0 : m_ctrl[i];
    e.wv = 1'b0;
    e.wi = '0;
    if (en && we != 4'b0 && idx < NC) begin
      v = nc[idx];
      for (int b = 0; b < 4; b++) if (we[b]) v[8*b +: 8] = wd[8*b +: 8];
      nc[idx] = v;
      e.wv = 1'b1;
      e.wi = WW'(idx);
    end

    if (m_snap) for (int j = 0; j < NS; j++) m_sh1[j] = stat_bus[j*32 +: 32];
    m_snap = en && we != 4'b0 && idx == SI;
    for (int j = 0; j < NS; j++) m_sh0[j] = stat_bus[j*32 +: 32];
    for (int i = 0; i < NC; i++) m_ctrl[i] = nc[i];

    for (int i = 0; i < NC; i++) e.ctrl[i*32 +: 32] = m_ctrl[i];
    e.rd0 = m_rd0; e.rd1 = m_rd1; e.oor = m_oor;
    exp_q.push_back(e);
  endtask

  // Monitor: an entry seen at one falling edge belongs to the next rising
  // edge, so it is popped at the falling edge after that.
  initial begin
    exp_t e;
    armed = 1'b0;
    forever begin
      @(negedge clk);
      if (armed && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_ctrl("ctrl_reg0", ctrl0, e.ctrl);
        check_ctrl("ctrl_reg1", ctrl1, e.ctrl);
        check("rddata0", bus0.bram_rddata, e.rd0);
        check("rddata1", bus1.bram_rddata, e.rd1);
        check("wr_valid0", 32'(v0), 32'(e.wv));
        check("wr_valid1", 32'(v1), 32'(e.wv));
        if (e.wv) begin
          check("wr_idx0", 32'(wi0), 32'(e.wi));
          check("wr_idx1", 32'(wi1), 32'(e.wi));
        end
        check("oor0", 32'(oc0), 32'(e.oor));
        check("oor1", 32'(oc1), 32'(e.oor));
      end
      armed = exp_q.size() > 0;
    end
  end

  initial begin
    int j;
    stat_nxt = '0;
    stat_bus = '0;
    drive(1'b0, 4'h0, '0, '0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_ctrl0_zero", 32'(|ctrl0), 32'h0);
    check("rst_rddata0", bus0.bram_rddata, 32'h0);
    check("rst_wr_valid0", 32'(v0), 32'h0);
    check("rst_wr_idx0", 32'(wi0), 32'h0);
    check("rst_oor0", 32'(oc0), 32'h0);
    rst = 1'b0;
    model_reset();

    // Reads of a control word and a status word after reset.
    stat_nxt[3*32 +: 32] = 32'h1234_5678;
    do_cycle(1'b1, 4'h0, 5, '0);
    do_cycle(1'b1, 4'h0, NC + 3, '0);
    do_cycle(1'b0, 4'h0, 0, '0);

    // Byte-enable merge and immediate readback.
    do_cycle(1'b1, 4'hF, 20, 32'h1111_1111);
    do_cycle(1'b1, 4'b0101, 20, 32'hAABB_CCDD);
    do_cycle(1'b1, 4'h0, 20, '0);
    do_cycle(1'b0, 4'h0, 0, '0);

    // Pulse register: visible one cycle, reads back zero.
    do_cycle(1'b1, 4'hF, 2, 32'h1);
    do_cycle(1'b1, 4'h0, 2, '0);
    do_cycle(1'b0, 4'h0, 0, '0);

    // Coherent snapshot through pulse register SI.
    stat_nxt[0 +: 32] = 32'h10;
    do_cycle(1'b0, 4'h0, 0, '0);
    do_cycle(1'b1, 4'hF, SI, 32'h1);
    do_cycle(1'b0, 4'h0, 0, '0);
    stat_nxt[0 +: 32] = 32'h20;
    do_cycle(1'b0, 4'h0, 0, '0);
    do_cycle(1'b1, 4'h0, NC, '0);
    do_cycle(1'b1, 4'hF, SI, 32'h1);
    do_cycle(1'b0, 4'h0, 0, '0);
    do_cycle(1'b0, 4'h0, 0, '0);
    do_cycle(1'b1, 4'h0, NC, '0);

    // Out of range read and write, then saturation of the counter.
    do_cycle(1'b1, 4'h0, NC + NS, '0);
    do_cycle(1'b1, 4'hF, NC + NS, 32'h5555_5555);
    do_cycle(1'b0, 4'h0, 0, '0);
    repeat (65540)
      do_cycle(1'b1, ($urandom_range(0, 1) != 0) ? 4'hF : 4'h0,
               NC + NS + int'($urandom_range(0, NIDX - NC - NS - 1)), $urandom);

    // Reset while a pulse is visible and a read result is held.
    do_cycle(1'b1, 4'h0, NC + 3, '0);
    do_cycle(1'b1, 4'hF, 2, 32'h5);
    @(posedge clk); #1;
    drive(1'b0, 4'h0, '0, '0);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_ctrl0_zero", 32'(|ctrl0), 32'h0);
    check("midrst_ctrl1_zero", 32'(|ctrl1), 32'h0);
    check("midrst_wr_valid0", 32'(v0), 32'h0);
    check("midrst_wr_valid1", 32'(v1), 32'h0);
    check("midrst_rddata0", bus0.bram_rddata, 32'h0);
    check("midrst_rddata1", bus1.bram_rddata, 32'h0);
    check("midrst_oor0", 32'(oc0), 32'h0);
    @(negedge clk); #1;
    rst = 1'b0;
    model_reset();
    do_cycle(1'b1, 4'hF, 7, 32'hCAFE_0001);
    do_cycle(1'b1, 4'h0, 7, '0);
    do_cycle(1'b0, 4'h0, 0, '0);

    // Randomised traffic across all regions.
    repeat (2000) begin
      if ($urandom_range(0, 7) == 0) begin
        j = int'($urandom_range(0, NS - 1));
        stat_nxt[j*32 +: 32] = $urandom;
      end
      do_cycle($urandom_range(0, 4) != 0,
               ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15)),
               int'($urandom_range(0, NIDX - 1)), $urandom);
    end
    do_cycle(1'b0, 4'h0, 0, '0);

    repeat (3) @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_bank_ctrl.md
Name: reg_bank_ctrl

Overview:
- Parametrised control/status register bank behind a BRAM-controller style port (AXI-Lite-to-BRAM bridge on the host side).
- Successor to the fixed 512+512 register controller. Adds:
  - parametrised counts;
  - byte-enable writes;
  - self-clearing pulse registers;
  - write-strobe notification;
  - optional coherent status snapshot;
  - out-of-range detection.
- Sits in the user clock domain between the PCIe control bridge and user logic.

Parameters:
- N_CTRL, 512, number of 32-bit control registers (word indices 0..N_CTRL-1).
- N_STAT, 512, number of 32-bit status registers (word indices N_CTRL..N_CTRL+N_STAT-1).
- ADDR_W, 12, byte-address width; word index = bram_addr[ADDR_W-1:2]; 2^(ADDR_W-2) >= N_CTRL+N_STAT required.
- N_PULSE, 8, control indices 0..N_PULSE-1 are pulse registers; N_PULSE < N_CTRL.
- SNAP_MODE, 0, 0 = status shadow sampled every cycle; 1 = status shadow captured only on snapshot pulse.
- SNAP_IDX, 0, pulse register whose write triggers the snapshot; must be < N_PULSE.

Ports:
- user_clk  in  1  the block's single clock.
- user_areset  in  1  asynchronous, active-high reset.
- bram_en  in  1  access enable.
- bram_we  in  4  byte write enables; nonzero = write, zero = read.
- bram_addr  in  ADDR_W  byte address.
- bram_wrdata  in  32  write data.
- bram_rddata  out  32  read data.
- ctrl_reg  out  N_CTRL*32  control register outputs; word i at [32i+31:32i].
- stat_reg  in  N_STAT*32  status inputs from user logic.
- ctrl_wr_valid  out  1  one-cycle strobe: a control register was written.
- ctrl_wr_idx  out  $clog2(N_CTRL)  index of that write.
- oor_count  out  16  saturating count of out-of-range accesses.

Behaviour:
- Reset (async assert, sync release):
  - ctrl_reg = 0, bram_rddata = 0, status shadow = 0;
  - ctrl_wr_valid = 0, ctrl_wr_idx = 0, oor_count = 0.
- Write (cycle T: bram_en=1, bram_we!=0, index < N_CTRL):
  - for each b with bram_we[b]=1, byte b of the register takes bram_wrdata[8b+7:8b];
  - other bytes are held;
  - new value is visible on ctrl_reg from T+1;
  - ctrl_wr_valid=1 and ctrl_wr_idx=index during T+1 only.
- Pulse registers (index < N_PULSE):
  - written value is visible on ctrl_reg during T+1 only;
  - the register returns to 0 at the end of T+1;
  - always reads back 0.
- Writes to the status region or out-of-range indices are dropped and do not alter state; out-of-range writes increment oor_count.
- Read (cycle T: bram_en=1, bram_we=0):
  - bram_rddata is registered and valid from T+1;
  - it holds until the next read completes; writes never change bram_rddata.
  - control index returns the current register value, including a write accepted at T-1.
  - status index returns the shadow word.
  - out-of-range index returns 32'hDEAD_BEEF and increments oor_count.
- Back-to-back accesses on consecutive cycles are all accepted; there are no wait states and no internal FSM stall.
- Status shadow:
  - SNAP_MODE=0: shadow <= stat_reg every cycle, one-cycle input pipeline.
  - SNAP_MODE=1: the whole shadow is loaded from stat_reg on the cycle the SNAP_IDX pulse is visible (T+1), giving a coherent multi-word read; otherwise it holds.
- oor_count saturates at 16'hFFFF.
- bram_en=0: no state change except pulse clearing and the SNAP_MODE=0 shadow update.
- Reset asserted mid-pulse or mid-read: all outputs return to reset values immediately; the pending strobe and read are lost.

Decomposition:
- Package reg_bank_pkg:
  - localparam DATA_W=32;
  - localparam OOR_RDATA=32'hDEAD_BEEF;
  - enum region_t {REGION_CTRL, REGION_STAT, REGION_OOR};
  - function decode_region(word index, N_CTRL, N_STAT).
- One sub-module, reg_bank_addr_dec: combinational index extraction, region classification, and pulse/snapshot flags.
- Storage, read mux and counters stay in the top level.

Test Plan:
- Reset, then read index 5 and index N_CTRL+3 with stat_reg word 3 = 0x1234_5678 -> bram_rddata = 0x0000_0000, then 0x1234_5678 one cycle after each read; oor_count = 0.
- Write 0xAABB_CCDD to index 20 with bram_we=4'b0101 over prior 0x1111_1111 -> ctrl_reg word 20 = 0x11BB_11DD at T+1; ctrl_wr_valid pulses one cycle with ctrl_wr_idx=20; an immediate readback returns 0x11BB_11DD.
- Write 0x1 to pulse index 2 -> ctrl_reg word 2 = 0x1 for exactly one cycle, then 0; readback of index 2 = 0.
- SNAP_MODE=1, SNAP_IDX=0:
  - stat word 0 = 0x10; pulse index 0;
  - change stat word 0 to 0x20;
  - read N_CTRL+0 -> 0x10;
  - pulse again, read -> 0x20.
- Read and write at index N_CTRL+N_STAT (out of range) -> read returns 0xDEAD_BEEF, the write alters nothing, oor_count = 2; after forcing 0xFFFF, one more out-of-range access keeps 0xFFFF.
- Assert user_areset during the cycle a pulse is visible -> ctrl_reg, ctrl_wr_valid and bram_rddata are 0 immediately; after release, a first access behaves normally.
